// File: rtl/weight_memory_compute_responder.sv
// Memory-side responder for the weight-memory load/compute protocol.
// One bank group per PE array, filled by a sequential load stream, read with 1-cycle latency.
module weight_memory_compute_responder #(
    parameter int WEIGHT_BANK_DEPTH           = 8,
    parameter int WEIGHT_BANK_BIT_WIDTH       = 8,
    parameter int WEIGHT_BUFFER_BANK_COUNT    = 8,
    parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_start,
    input  logic load_valid,
    input  logic [WEIGHT_BANK_BIT_WIDTH*WEIGHT_BUFFER_BANK_COUNT-1:0] load_data,
    output logic load_ready,
    output logic load_busy,
    output logic load_done,
    input  logic compute_enable,
    input  logic [$clog2(WEIGHT_BANK_DEPTH)-1:0] compute_address [NUMBER_OF_PE_ARRAYS_PER_ROW],
    output logic [WEIGHT_BANK_BIT_WIDTH*WEIGHT_BUFFER_BANK_COUNT-1:0]
        weight_data [NUMBER_OF_PE_ARRAYS_PER_ROW]
);

    localparam int WordWidth = WEIGHT_BANK_BIT_WIDTH * WEIGHT_BUFFER_BANK_COUNT;
    localparam int AddrWidth = $clog2(WEIGHT_BANK_DEPTH);
    localparam int ArrWidth  = (NUMBER_OF_PE_ARRAYS_PER_ROW > 1) ?
                               $clog2(NUMBER_OF_PE_ARRAYS_PER_ROW) : 1;
    localparam logic [AddrWidth-1:0] LastWord  = AddrWidth'(WEIGHT_BANK_DEPTH - 1);
    localparam logic [ArrWidth-1:0]  LastArray = ArrWidth'(NUMBER_OF_PE_ARRAYS_PER_ROW - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   word_idx_q, word_idx_d;
    logic [ArrWidth-1:0]    array_idx_q, array_idx_d;
    logic                   write_en;
    logic [WordWidth-1:0]   mem_q [NUMBER_OF_PE_ARRAYS_PER_ROW][WEIGHT_BANK_DEPTH];
    logic [WordWidth-1:0]   mem_d [NUMBER_OF_PE_ARRAYS_PER_ROW][WEIGHT_BANK_DEPTH];
    logic [WordWidth-1:0]   weight_data_q [NUMBER_OF_PE_ARRAYS_PER_ROW];
    logic [WordWidth-1:0]   weight_data_d [NUMBER_OF_PE_ARRAYS_PER_ROW];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            word_idx_q    <= '0;
            array_idx_q   <= '0;
            weight_data_q <= '{default: '0};
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            array_idx_q   <= array_idx_d;
            weight_data_q <= weight_data_d;
        end
    end

    // Contents survive reset, so a partial load stays readable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        array_idx_d = array_idx_q;
        write_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d     = StLoad;
                    word_idx_d  = '0;
                    array_idx_d = '0;
                end
            end
            StLoad: begin
                if (load_valid) begin
                    write_en = 1'b1;
                    if (word_idx_q == LastWord) begin
                        word_idx_d = '0;
                        if (array_idx_q == LastArray) begin
                            state_d     = StDone;
                            array_idx_d = '0;
                        end else begin
                            array_idx_d = array_idx_q + ArrWidth'(1);
                        end
                    end else begin
                        word_idx_d = word_idx_q + AddrWidth'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (write_en) begin
            mem_d[array_idx_q][word_idx_q] = load_data;
        end
    end

    // Reads sample mem_q, so a same-edge write is seen only by the next read.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_PE_ARRAYS_PER_ROW; i++) begin
            weight_data_d[i] = weight_data_q[i];
            if (compute_enable) begin
                if (int'(compute_address[i]) < WEIGHT_BANK_DEPTH) begin
                    weight_data_d[i] = mem_q[i][compute_address[i]];
                end else begin
                    weight_data_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        load_ready = (state_q == StLoad);
        load_busy  = (state_q == StLoad);
        load_done  = (state_q == StDone);
    end

    assign weight_data = weight_data_q;

endmodule

// File: tb/tb_weight_memory_compute_responder.sv
// Directed bench for weight_memory_compute_responder: reset, loads, reads, collision, abort.
module tb_weight_memory_compute_responder;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load_start;
    logic        load_valid;
    logic [63:0] load_data;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        compute_enable;
    logic [2:0]  compute_address [N];
    logic [63:0] weight_data [N];

    int tests = 0;
    int fails = 0;

    weight_memory_compute_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .load_start      (load_start),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_ready      (load_ready),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .compute_enable  (compute_enable),
        .compute_address (compute_address),
        .weight_data     (weight_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_val(input logic [15:0] base, input int a, input int w);
        return {32'h0, base, 8'(a), 8'(w)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one load; negative start_at/coll_idx/abort_after disable that event.
    task automatic do_load(input logic [15:0] base, input bit toggle, input int start_at,
                           input int coll_idx, input int abort_after,
                           output int writes, output int ready_cyc, output int dones,
                           output logic [63:0] coll_obs, output bit done_follows);
        bit coll_pending;
        bit prev_ready;
        bit writing;
        writes = 0; ready_cyc = 0; dones = 0; coll_obs = '0; done_follows = 0;
        coll_pending = 0; prev_ready = 0;
        load_start = 1'b1;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            load_start     = 1'b0;
            compute_enable = 1'b0;
            if (coll_pending) begin
                coll_obs     = weight_data[3];
                coll_pending = 0;
            end
            if (dones > 0 && !load_done) break;
            if (load_done) begin
                dones++;
                if (prev_ready) done_follows = 1;
            end
            if (load_ready) ready_cyc++;
            writing = load_ready && (!toggle || (cyc % 2 == 0));
            if (writing && writes == abort_after) begin
                resetn     = 1'b0;
                load_valid = 1'b0;
                load_start = 1'b1;
                tick();
                resetn     = 1'b1;
                load_start = 1'b0;
                break;
            end
            load_valid = writing;
            if (writing) begin
                load_data = word_val(base, writes / 8, writes % 8);
                if (writes == start_at) load_start = 1'b1;
                if (writes == coll_idx) begin
                    compute_enable     = 1'b1;
                    compute_address[3] = 3'd5;
                    coll_pending       = 1;
                end
                writes++;
            end
            prev_ready = load_ready;
            tick();
        end
        load_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        compute_enable = 1'b0;
        for (int i = 0; i < N; i++) compute_address[i] = '0;
        tick(); tick();
        resetn = 1'b1;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (weight_data[i] !== 64'h0) begin
                fails++;
                $display("FAIL reset_wd[%0d]: got %h want 0", i, weight_data[i]);
            end
        end
        tests++;
        if ({load_ready, load_busy, load_done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: got rdy/busy/done=%b want 000",
                     {load_ready, load_busy, load_done});
        end
    endtask

    task automatic test_full_load();
        int w, r, d; logic [63:0] c; bit f;
        do_load(16'h0, 0, -1, -1, -1, w, r, d, c, f);
        tests++;
        if (w !== 64) begin fails++; $display("FAIL full_writes: got %0d want 64", w); end
        tests++;
        if (r !== 64) begin fails++; $display("FAIL full_ready_cycles: got %0d want 64", r); end
        tests++;
        if (d !== 1 || f !== 1'b1) begin
            fails++;
            $display("FAIL full_done: got dones=%0d follows=%0d want 1/1", d, f);
        end
        tests++;
        if ({load_ready, load_busy, load_done} !== 3'b000) begin
            fails++;
            $display("FAIL full_idle: got %b want 000", {load_ready, load_busy, load_done});
        end
    endtask

    task automatic test_read_after_load();
        logic [63:0] exp;
        compute_enable = 1'b1;
        for (int i = 0; i < N; i++) compute_address[i] = 3'(i);
        tick();
        compute_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp = word_val(16'h0, i, i);
            tests++;
            if (weight_data[i] !== exp) begin
                fails++;
                $display("FAIL read_diag[%0d]: got %h want %h", i, weight_data[i], exp);
            end
        end
        for (int i = 0; i < N; i++) compute_address[i] = 3'(7 - i);
        tick();
        for (int i = 0; i < N; i++) begin
            exp = word_val(16'h0, i, i);
            tests++;
            if (weight_data[i] !== exp) begin
                fails++;
                $display("FAIL read_hold[%0d]: got %h want %h", i, weight_data[i], exp);
            end
        end
        compute_enable = 1'b1;
        for (int i = 0; i < N; i++) compute_address[i] = 3'((i + 3) % 8);
        tick();
        compute_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp = word_val(16'h0, i, (i + 3) % 8);
            tests++;
            if (weight_data[i] !== exp) begin
                fails++;
                $display("FAIL read_rot[%0d]: got %h want %h", i, weight_data[i], exp);
            end
        end
    endtask

    task automatic test_toggle_restart();
        int w, r, d; logic [63:0] c; bit f; logic [63:0] exp;
        do_load(16'h1, 1, 30, -1, -1, w, r, d, c, f);
        tests++;
        if (w !== 64) begin fails++; $display("FAIL toggle_writes: got %0d want 64", w); end
        tests++;
        if (d !== 1) begin fails++; $display("FAIL toggle_dones: got %0d want 1", d); end
        tests++;
        if (r !== 127) begin fails++; $display("FAIL toggle_ready_cycles: got %0d want 127", r); end
        compute_enable = 1'b1;
        for (int i = 0; i < N; i++) compute_address[i] = 3'(7 - i);
        tick();
        compute_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp = word_val(16'h1, i, 7 - i);
            tests++;
            if (weight_data[i] !== exp) begin
                fails++;
                $display("FAIL toggle_read[%0d]: got %h want %h", i, weight_data[i], exp);
            end
        end
    endtask

    task automatic test_collision();
        int w, r, d; logic [63:0] c; bit f;
        do_load(16'h2, 0, -1, 29, -1, w, r, d, c, f);
        tests++;
        if (c !== word_val(16'h1, 3, 5)) begin
            fails++;
            $display("FAIL collision_old: got %h want %h", c, word_val(16'h1, 3, 5));
        end
        compute_enable = 1'b1;
        compute_address[3] = 3'd5;
        tick();
        compute_enable = 1'b0;
        tests++;
        if (weight_data[3] !== word_val(16'h2, 3, 5)) begin
            fails++;
            $display("FAIL collision_new: got %h want %h", weight_data[3], word_val(16'h2, 3, 5));
        end
    endtask

    task automatic test_reset_midload();
        int w, r, d; logic [63:0] c; bit f;
        logic [63:0] exp [N];
        do_load(16'h3, 0, -1, -1, 20, w, r, d, c, f);
        tests++;
        if ({load_ready, load_busy, load_done} !== 3'b000) begin
            fails++;
            $display("FAIL abort_idle: got %b want 000", {load_ready, load_busy, load_done});
        end
        tick();
        tests++;
        if (load_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_start_ignored: got ready=%b want 0", load_ready);
        end
        // Arrays 0,1 and words 0..3 of array 2 are new; the rest keep the previous load.
        compute_enable = 1'b1;
        compute_address[0] = 3'd0; exp[0] = word_val(16'h3, 0, 0);
        compute_address[1] = 3'd7; exp[1] = word_val(16'h3, 1, 7);
        compute_address[2] = 3'd3; exp[2] = word_val(16'h3, 2, 3);
        compute_address[3] = 3'd0; exp[3] = word_val(16'h2, 3, 0);
        compute_address[4] = 3'd1; exp[4] = word_val(16'h2, 4, 1);
        compute_address[5] = 3'd2; exp[5] = word_val(16'h2, 5, 2);
        compute_address[6] = 3'd4; exp[6] = word_val(16'h2, 6, 4);
        compute_address[7] = 3'd6; exp[7] = word_val(16'h2, 7, 6);
        tick();
        compute_address[2] = 3'd4;
        tick();
        compute_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == 2) exp[2] = word_val(16'h2, 2, 4);
            tests++;
            if (weight_data[i] !== exp[i]) begin
                fails++;
                $display("FAIL abort_retained[%0d]: got %h want %h", i, weight_data[i], exp[i]);
            end
        end
        do_load(16'h4, 0, -1, -1, -1, w, r, d, c, f);
        tests++;
        if (w !== 64 || d !== 1) begin
            fails++;
            $display("FAIL reload_counts: got writes=%0d dones=%0d want 64/1", w, d);
        end
        compute_enable = 1'b1;
        for (int i = 0; i < N; i++) compute_address[i] = 3'(i);
        tick();
        compute_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (weight_data[i] !== word_val(16'h4, i, i)) begin
                fails++;
                $display("FAIL reload_read[%0d]: got %h want %h", i, weight_data[i],
                         word_val(16'h4, i, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_read_after_load();
        test_toggle_restart();
        test_collision();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
